// File: rtl/calc_pkg.sv
// Shared calculator encodings: one-hot sequencer states and the MUL/DIV op code.
package calc_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD   = 5'b00010,
    S_MUL_IT = 5'b00100,
    S_DIV_IT = 5'b01000,
    S_FINISH = 5'b10000
  } state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Shared WIDTH+1-bit add/sub with the acc ({hi,lo} / {rem,quo}) and operand registers.
// MULDIV_EARLY_TERM_EN adds the early-exit detect and the right-align barrel shift.
module muldiv_dp
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     step,
  input  logic                     op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
`ifdef MULDIV_EARLY_TERM_EN
  input  logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     early,
`endif
  output logic                     hi_nz,
  output logic [2*WIDTH-1:0]       acc
);

  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   sh_rem;
  logic [WIDTH:0]     x;
  logic [WIDTH:0]     y;
  logic [WIDTH:0]     sum;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] mul_fin;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] acc_nxt;
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   mask;
`endif

  always_comb begin
    sh_rem = acc[2*WIDTH-2:WIDTH-1];
    // One adder: DIV subtracts via inverted operand plus carry-in
    if (op == OP_DIV) begin
      x = {1'b0, sh_rem};
      y = ~{1'b0, opnd};
    end else begin
      x = {1'b0, acc[2*WIDTH-1:WIDTH]};
      y = acc[0] ? {1'b0, opnd} : '0;
    end
    sum     = x + y + {{WIDTH{1'b0}}, (op == OP_DIV)};
    ge      = ~sum[WIDTH];
    mul_nxt = {sum, acc[WIDTH-1:1]};
    div_nxt = {(ge ? sum[WIDTH-1:0] : sh_rem), acc[WIDTH-2:0], ge};
`ifdef MULDIV_EARLY_TERM_EN
    // Low cnt bits of lo still hold unconsumed multiplier bits
    mask    = (WIDTH'(1) << cnt) - WIDTH'(1);
    early   = ((mul_nxt[WIDTH-1:0] & mask) == '0);
    mul_fin = early ? (mul_nxt >> cnt) : mul_nxt;
`else
    mul_fin = mul_nxt;
`endif
    hi_nz = |mul_fin[2*WIDTH-1:WIDTH];

    acc_nxt = acc;
    if (clr) begin
      acc_nxt = '0;
    end else if (load) begin
      acc_nxt = {{WIDTH{1'b0}}, ((op == OP_DIV) ? a : b)};
    end else if (step) begin
      acc_nxt = (op == OP_DIV) ? div_nxt : mul_fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      opnd <= '0;
    end else begin
      acc <= acc_nxt;
      if (load) opnd <= (op == OP_DIV) ? b : a;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MUL/DIV sequencer: FSM, iteration counter, status flags; arithmetic lives in muldiv_dp.
// MULDIV_EARLY_TERM_EN lets MUL exit once the remaining multiplier bits are zero.
module muldiv_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic               Flag,
  output logic               Err
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             div0;
  logic             dp_clr;
  logic             dp_load;
  logic             dp_step;
  logic             dp_op;
  logic             hi_nz;
  logic             mul_exit;

  always_comb begin
    accept  = (state == S_IDLE) && Start;
    div0    = (Op == OP_DIV) && (B == '0);
    // Operands go straight into the datapath on the Start edge; LOAD only arms the counter
    dp_clr  = accept && div0;
    dp_load = accept && !div0;
    dp_step = (state == S_MUL_IT) || (state == S_DIV_IT);
    dp_op   = (state == S_IDLE) ? Op : op_q;
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic early;
  assign mul_exit = early;
`else
  assign mul_exit = (cnt == '0);
`endif

  muldiv_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (dp_clr),
    .load  (dp_load),
    .step  (dp_step),
    .op    (dp_op),
    .a     (A),
    .b     (B),
`ifdef MULDIV_EARLY_TERM_EN
    .cnt   (cnt),
    .early (early),
`endif
    .hi_nz (hi_nz),
    .acc   (Result)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      op_q  <= OP_MUL;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Flag  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q <= Op;
            Flag <= 1'b0;
            Err  <= div0;
            if (div0) begin
              Done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              Busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cnt   <= CNT_W'(WIDTH - 1);
          state <= (op_q == OP_DIV) ? S_DIV_IT : S_MUL_IT;
        end
        S_MUL_IT: begin
          cnt <= cnt - 1'b1;
          if (mul_exit) begin
            Done  <= 1'b1;
            Flag  <= hi_nz;
            state <= S_FINISH;
          end
        end
        S_DIV_IT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            Done  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller that runs the MUL and DIV operations of the simple calculator. Multiply is shift-add; divide is restoring shift-subtract. Both share one WIDTH+1-bit adder/subtractor.
The calculator top FSM pulses Start from its MUL/DIV states and waits for Done. Done then carries a full-width product or quotient/remainder plus status flags.

Parameters:
WIDTH, 16, operand width in bits (4..32)
CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset (asserted when 0)
Start  in  1  one-cycle request; sampled only in IDLE
Op  in  1  0 = multiply, 1 = divide; sampled with Start
A  in  WIDTH  multiplicand / dividend; sampled with Start
B  in  WIDTH  multiplier / divisor; sampled with Start
Busy  out  1  high from the cycle after Start is accepted until FINISH is exited
Done  out  1  one-cycle pulse; Result/Flag/Err are valid that cycle and held until the next accepted Start
Result  out  2*WIDTH  MUL: full product; DIV: {remainder, quotient}
Flag  out  1  MUL: product exceeds WIDTH bits (Result[2W-1:W] != 0); DIV: 0
Err  out  1  DIV with B == 0

Behaviour:
- Reset (Reset==0, any state, mid-operation included): state=IDLE, Busy=0, Done=0, Result=0, Flag=0, Err=0, counter=0. Any in-flight operation is discarded with no Done.
- States, one-hot: IDLE, LOAD, MUL_IT, DIV_IT, FINISH.
- IDLE:
  - If Start, latch A, B, Op.
  - If Op=1 and B==0, go directly to FINISH with Err=1 and Result=0.
  - Otherwise go to LOAD.
  - Start is ignored in every state other than IDLE, with no queuing.
- LOAD:
  - MUL: acc = {WIDTH zeros, B}, mcand = A.
  - DIV: rem = 0, quo = A, dvsr = B.
  - counter = WIDTH-1.
  - Next state is MUL_IT or DIV_IT according to Op.
- MUL_IT, per cycle:
  - sum = acc[2W-1:W] + (acc[0] ? mcand : 0), computed WIDTH+1 bits wide.
  - acc = {sum, acc[W-1:1]}, i.e. shift right by one including the carry.
- DIV_IT, per cycle:
  - trial = {rem[W-2:0], quo[W-1]} - dvsr, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial[W-1:0] and shift 1 into quo.
  - Otherwise: rem = the shifted value and shift 0 into quo.
- Both iteration states:
  - counter decrements each cycle.
  - When counter==0, move to FINISH.
- FINISH:
  - Done=1.
  - Result = acc (MUL) or {rem, quo} (DIV).
  - Flag = |acc[2W-1:W] for MUL, else 0.
  - Next state is IDLE unconditionally.
- Latency, counting the Start edge as cycle 0:
  - Normal operation: Done is high in cycle WIDTH+2 (18 cycles for WIDTH=16).
  - Divide-by-zero: Done is high in cycle 1.
  - Throughput: the next Start is accepted in the cycle after Done.
- Busy is 0 in IDLE, including the cycle Start is sampled, and 1 in LOAD, MUL_IT, DIV_IT and FINISH.
- Flag and Err clear on the next accepted Start.
- Operands are unsigned. No sign handling.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined:
  - MUL_IT exits to FINISH early once the remaining unshifted multiplier bits are all zero.
  - acc is right-aligned by the remaining count in that exit cycle using a barrel shift.
  - Result is identical to the non-early path. Latency is 3..WIDTH+2 cycles.
  - Operand 0 or 1 finishes fastest.
  - DIV is unaffected.
- Undefined: fixed latency as above. Bench latency checks are conditional on the macro.

Decomposition:
- Package calc_pkg:
  - One-hot state localparams for IDLE/LOAD/MUL_IT/DIV_IT/FINISH.
  - OP_MUL=1'b0 and OP_DIV=1'b1.
  - Shared with the calculator top for op encoding.
- One sub-module, muldiv_dp: the shared WIDTH+1-bit add/sub plus the acc/rem/quo shift registers.
  - Controlled by the sequencer's add/sub select, load and shift enables.
  - The sequencer top holds only the FSM, counter, flags and output registers.

Test Plan:
- MUL 300*200 -> Done at cycle 18, Result=60000 (0x0000EA60), Flag=0, Err=0; Busy high cycles 1..18.
- MUL 1000*1000 -> Result=0x000F4240, Flag=1; MUL 0xFFFF*0xFFFF -> Result=0xFFFE0001, Flag=1.
- DIV 100/7 -> Result={16'd2, 16'd14}; DIV 5/9 -> {16'd5, 16'd0}; DIV 0xFFFF/1 -> {0, 0xFFFF}; all with Flag=0 and Err=0.
- DIV 42/0 -> Done at cycle 1, Err=1, Result=0, Busy never high; then MUL 3*4 -> Result=12, Err=0.
- Start with MUL 7*9, then Reset low at cycle 6 -> all outputs 0 immediately, no Done pulse. After release, DIV 9/3 -> {0, 3}.
- Start re-pulsed during Busy (cycles 5 and 10) with different operands -> ignored; original Result is produced, and Start held high through Done re-triggers only from IDLE.
